// File: rtl/looper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : looper_pkg
//  Purpose  : Shared definitions for the memory-dump transmitter: FSM state
//             encoding, byte-count helper and checksum width.
//  Revision : 1.0  initial release
// ============================================================================
package looper_pkg;

    // Dump sequencer states (explicitly encoded, 3 bits)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_GAP  = 3'd4,
        ST_NEXT = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    // Width of the running checksum byte
    localparam int c_ck_w = 8;

    // Number of bytes per memory word
    function automatic int byte_count(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_ser.sv
`default_nettype none
// ============================================================================
//  Module   : dump_ser
//  Purpose  : Word-to-byte serializer. Holds the captured memory word in a
//             shift register, counts remaining bytes and presents the MSB byte
//             to the SPART. With MEM_DUMP_CHECKSUM_EN defined it also keeps an
//             8-bit modular sum of all transmitted bytes and can load it as a
//             final byte.
//  Ports    : clk, rst_n        clock, async active-low reset
//             clr               clear checksum (new dump accepted)
//             cap               load mem_dout, byte counter = bytes-1
//             shift            shift left one byte, count down
//             send             sequencer is in SEND
//             ck_load          load checksum as the only remaining byte
//             tx_rdy           SPART ready
//             mem_dout         memory read data
//             tx_ld, tx_data   byte load strobe and byte
//             last_byte        counter is at zero (next GAP underflows)
//  Macro    : MEM_DUMP_CHECKSUM_EN
//  Revision : 1.0  initial release
// ============================================================================
module dump_ser
    import looper_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap,
    input  logic              shift,
    input  logic              send,
    input  logic              ck_load,
    input  logic              tx_rdy,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              tx_ld,
    output logic [7:0]        tx_data,
    output logic              last_byte
);

    localparam int c_bytes = byte_count(DATA_W);
    localparam int c_cnt_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(c_bytes - 1);

    logic [DATA_W-1:0]  r_shift;
    logic [c_cnt_w-1:0] r_cnt;

    assign tx_ld     = send & tx_rdy;
    assign tx_data   = r_shift[DATA_W-1 -: 8];
    assign last_byte = (r_cnt == '0);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [c_ck_w-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (tx_ld) begin
            r_sum <= r_sum + tx_data;
        end
    end
`else
    logic w_unused_ck;
    assign w_unused_ck = ck_load & clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (cap) begin
            r_shift <= mem_dout;
            r_cnt   <= c_cnt_top;
        end else if (shift) begin
            r_shift <= r_shift << 8;
            // Hold at zero on the last byte; the sequencer has already seen
            // the underflow condition and moves on.
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
`ifdef MEM_DUMP_CHECKSUM_EN
        end else if (ck_load) begin
            // Checksum goes out as a one-byte "word" through SEND/GAP
            r_shift <= DATA_W'(r_sum) << (DATA_W - c_ck_w);
            r_cnt   <= '0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_tx
//  Purpose  : Reads memory words start_addr..stop_addr (inclusive) and sends
//             them byte-wise, MSB first, to a SPART transmitter. Owns the
//             sequencing FSM and address counter; byte serialization lives
//             in dump_ser.
//  Ports    : clk, rst_n              clock, async active-low reset
//             start, start_addr,
//             stop_addr               dump request and inclusive range
//             mem_en, mem_addr,
//             mem_dout                1-cycle-latency memory read port
//             tx_rdy, tx_ld, tx_data  SPART byte interface
//             busy, done, err         status
//  Macro    : MEM_DUMP_CHECKSUM_EN (append 8-bit sum byte after the data)
//  Revision : 1.0  initial release
// ============================================================================
module mem_dump_tx
    import looper_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              tx_rdy,
    output logic              tx_ld,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam bit c_ck_en = 1'b1;
`else
    localparam bit c_ck_en = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stop;
    logic              r_err;
    logic              w_at_stop;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_ck_phase;
    logic              w_ck_load;
    logic              w_cap;
    logic              w_shift;
    logic              w_send;

    assign w_at_stop = (r_addr == r_stop);
    assign w_accept  = (r_state == ST_IDLE) && start;
    assign mem_addr  = r_addr;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic r_ck_phase;

    // Set while the checksum byte is in flight so GAP ends the dump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ck_phase <= 1'b0;
        end else if (w_accept) begin
            r_ck_phase <= 1'b0;
        end else if (w_ck_load) begin
            r_ck_phase <= 1'b1;
        end
    end

    assign w_ck_phase = r_ck_phase;
    assign w_ck_load  = (r_state == ST_NEXT) && w_at_stop;
`else
    assign w_ck_phase = 1'b0;
    assign w_ck_load  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (stop_addr < start_addr) ? ST_FIN : ST_RD;
                end
            end
            ST_RD:   w_next = ST_CAP;
            ST_CAP:  w_next = ST_SEND;
            ST_SEND: w_next = tx_rdy ? ST_GAP : ST_SEND;
            ST_GAP: begin
                if (!w_last_byte) begin
                    w_next = ST_SEND;
                end else begin
                    w_next = w_ck_phase ? ST_FIN : ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Compare before increment so the top address never wraps
                if (w_at_stop) begin
                    w_next = c_ck_en ? ST_SEND : ST_FIN;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_en  = (r_state == ST_RD);
        busy    = (r_state != ST_IDLE);
        done    = (r_state == ST_FIN);
        err     = (r_state == ST_FIN) && r_err;
        w_cap   = (r_state == ST_CAP);
        w_shift = (r_state == ST_GAP);
        w_send  = (r_state == ST_SEND);
    end

    // Address sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_stop <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_addr <= start_addr;
            r_stop <= stop_addr;
            r_err  <= (stop_addr < start_addr);
        end else if ((r_state == ST_NEXT) && !w_at_stop) begin
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    dump_ser #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_accept),
        .cap       (w_cap),
        .shift     (w_shift),
        .send      (w_send),
        .ck_load   (w_ck_load),
        .tx_rdy    (tx_rdy),
        .mem_dout  (mem_dout),
        .tx_ld     (tx_ld),
        .tx_data   (tx_data),
        .last_byte (w_last_byte)
    );

endmodule
`default_nettype wire
